// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the stopwatch start/stop push-button.
// Raw pin -> 2-flop synchronizer -> debounce counter -> press/release
// strobes and run toggle. Optional long-press clear, built only when the
// macro BTN_LONGPRESS_EN is defined.
// The release strobe port is named `rel` because `release` is a reserved word.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic rel,
  output logic run,
  output logic clear
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] cnt;
  logic          accept;
  logic          rise;

  // Two-flop synchronizer for the asynchronous button pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    accept = (s2 != btn_level) && (cnt == DMAX);
    rise   = accept && s2;
  end

  // Debounce counter and accepted level; any matching sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      cnt <= '0;
    end else if (cnt == DMAX) begin
      cnt       <= '0;
      btn_level <= s2;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

  // Single-cycle strobes registered on the edge the debounced level changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= rise;
      rel   <= accept && !s2;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int unsigned LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LW-1:0] LMAX = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold;
  logic          fired;
  logic          hold_hit;

  // Long press detected on the edge the hold count reaches its terminal value.
  always_comb begin
    hold_hit = btn_level && !fired && (hold == LMAX);
  end

  // Hold counter: idles at zero while released (including the press edge,
  // where the old level is still 0), counts while held, parks once fired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold  <= '0;
      fired <= 1'b0;
      clear <= 1'b0;
    end else begin
      clear <= hold_hit;
      if (!btn_level) begin
        hold  <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (hold == LMAX) begin
          fired <= 1'b1;
        end else begin
          hold <= hold + LW'(1);
        end
      end
    end
  end

  // Run toggles on each accepted press; a long press forces it off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
    end else if (hold_hit) begin
      run <= 1'b0;
    end else if (rise) begin
      run <= ~run;
    end
  end
`else
  // No long-press support: clear is never asserted.
  assign clear = 1'b0;

  // Run toggles on each accepted press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
    end else if (rise) begin
      run <= ~run;
    end
  end
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=16).
// Long-press expectations follow BTN_LONGPRESS_EN as defined for the build.
module tb_btn_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned L = 16;
`ifdef BTN_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic btn_level, press, rel, run, clear;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .press(press), .rel(rel), .run(run), .clear(clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int n_rel = 0;

  typedef struct {
    int   e;
    logic p, r, c, run, lvl;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: sample history and behavioural outcome.
  bit raw_h[$];
  bit s2_h[$];
  int m_e;
  bit m_level;
  bit m_run;
  int m_press_edge;

  int edge_n;
  always @(posedge clk or posedge rst)
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_h.delete();
    s2_h.delete();
    m_e = 0;
    m_level = 1'b0;
    m_run = 1'b0;
    m_press_edge = -1;
  endtask

  // Predict the outcome of the next edge from the sample sampled at it:
  // the debounced level follows a value once the synchronized stream has
  // shown it for D consecutive edges; a press held L edges triggers clear.
  task automatic model_edge(input bit v);
    bit s2v, flip, pr, rl, cl;
    exp_t x;
    m_e++;
    raw_h.push_back(v);
    s2v = (raw_h.size() >= 3) ? raw_h[raw_h.size()-3] : 1'b0;
    s2_h.push_back(s2v);
    flip = 1'b0;
    if (s2_h.size() >= D) begin
      flip = 1'b1;
      for (int i = 0; i < int'(D); i++)
        if (s2_h[s2_h.size()-1-i] == m_level) flip = 1'b0;
    end
    pr = flip && !m_level;
    rl = flip && m_level;
    cl = LP && m_level && (m_press_edge >= 0) && (m_e == m_press_edge + int'(L));
    if (pr) begin
      m_level = 1'b1;
      m_run = !m_run;
      m_press_edge = m_e;
    end
    if (rl) begin
      m_level = 1'b0;
      m_press_edge = -1;
    end
    if (cl) m_run = 1'b0;
    if (pr || rl || cl) begin
      x.e = m_e; x.p = pr; x.r = rl; x.c = cl; x.run = m_run; x.lvl = m_level;
      exp_q.push_back(x);
    end
  endtask

  // Drive one sample (at the falling edge), predict it, advance one cycle.
  task automatic step(input bit v);
    btn_raw = v;
    model_edge(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {btn_level, press, rel, run, clear}, 5'b0);
  endtask

  // Asynchronous reset mid-cycle with the pin toggling, then a clean release.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'($urandom);
      @(negedge clk);
    end
    chk_zero("rst_held");
    exp_q.delete();
    model_reset();
    n_press = 0;
    n_rel = 0;
    rst = 1'b0;
    step(1'b0);
    chk_zero("rst_first_cycle");
  endtask

  // Scoreboard monitor: compares every strobe edge with the predicted event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (press) n_press++;
        if (rel) n_rel++;
        while (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
          errors++;
          checks++;
          $display("FAIL missed_event: edge %0d got no strobe, expected p=%0b r=%0b c=%0b",
                   exp_q[0].e, exp_q[0].p, exp_q[0].r, exp_q[0].c);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
          exp_t x;
          x = exp_q.pop_front();
          chk("event", {press, rel, clear, run, btn_level}, {x.p, x.r, x.c, x.run, x.lvl});
        end else if (press || rel || clear) begin
          chk("unexpected_strobe", {press, rel, clear}, 3'b000);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v;
    int unsigned len;
    rst = 1'b1;
    btn_raw = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state, then a clean press held.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1);
      if (i == 5) chk("pre_press_level", {btn_level, press, run}, 3'b000);
      if (i == 6) chk("press_edge6", {btn_level, press, run}, 3'b111);
      if (i == 7) chk("press_low_edge7", press, 1'b0);
    end
    chk("no_release_while_held", n_rel, 0);
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("released_level", {btn_level, run}, 2'b01);

    // Bounce train shorter than the debounce window.
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("bounce_no_change", {btn_level, run, 30'(n_press)}, {1'b0, 1'b1, 30'd1});

    // Press, release, second press.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("run_held_after_release", {btn_level, run}, 2'b01);
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("two_press_one_release", {n_press, n_rel}, {32'd2, 32'd1});
    chk("second_press_run", run, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0);

    // Long press held 40 cycles.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1'b1);
      if (i == 21) chk("clear_not_early", clear, 1'b0);
      if (i == 22) chk("long_clear", {clear, run}, {LP, !LP});
      if (i == 23) chk("clear_one_cycle", clear, 1'b0);
    end
    chk("long_run_final", run, !LP);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0);
      if (i == 5) chk("long_release_not_early", rel, 1'b0);
      if (i == 6) chk("long_release_strobe", {rel, run}, {1'b1, !LP});
    end

    // Reset while held, then re-detection of the held button.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1);
    chk("pre_reset_state", {btn_level, run}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid_press");
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    model_reset();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1);
      if (i == 5) chk("repress_not_early", press, 1'b0);
      if (i == 6) chk("repress_edge6", {btn_level, press, run}, 3'b111);
    end
    for (int i = 0; i < 10; i++) step(1'b0);

    // Randomized bouncing and holding against the reference model.
    do_reset();
    for (int s = 0; s < 160; s++) begin
      v = 1'($urandom);
      if ($urandom_range(0, 4) == 0) len = $urandom_range(16, 30);
      else len = $urandom_range(1, 7);
      for (int unsigned k = 0; k < len; k++) step(v);
    end
    for (int i = 0; i < 30; i++) step(1'b0);
    chk("final_level_run", {btn_level, run}, {m_level, m_run});
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
